uart_loader: RTL and testbench
==============================

# uart_loader

Host-side command engine that sits on the byte interface of the UART block (its rx FIFO read side and tx FIFO write side). It parses a small binary protocol arriving over the serial line, writes the payload into program memory one 32-bit word at a time, and answers each command with a one-byte status. It is the boot path: the CPU is held stopped (`cpu_run`=0) until the host sends the Go command.

## Interface
- `ADDR_W`, 14: width of the memory word address; the received 16-bit address is truncated to this width.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_empty`  in  1  UART rx FIFO empty.
- `r_data`  in  8  rx FIFO head byte; valid whenever `rx_empty`=0.
- `rd_uart`  out  1  pop rx FIFO; `r_data` is consumed on this edge.
- `tx_full`  in  1  UART tx FIFO full.
- `wr_uart`  out  1  push `w_data` into tx FIFO.
- `w_data`  out  8  status byte to transmit.
- `mem_we`  out  1  one-cycle word write strobe.
- `mem_addr`  out  ADDR_W  word address, registered.
- `mem_wdata`  out  32  write data, registered.
- `cpu_run`  out  1  CPU release; sticky once set.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Protocol bytes:
  - `'W'` (0x57), then ADDR_LO, ADDR_HI, N, then 4·N data bytes. Each word is little-endian (first byte → bits 7:0). N=0 means 256 words.
  - `'G'` (0x47): set `cpu_run`.
  - Any other command byte: reply `'?'` (0x3F) and return to IDLE.
- Replies: W and G each answer `'K'` (0x4B) after completion.
- States and transitions:
  - IDLE: byte → W_ADDR0 (on 'W'), ACK with 'K' and `cpu_run`←1 (on 'G'), or ACK with '?' (any other byte).
  - W_ADDR0 → W_ADDR1 → W_COUNT → DATA.
  - DATA collects 4 bytes, then → WRITE.
  - WRITE → DATA while words remain, else → ACK.
  - ACK → IDLE.
- Pop rule: in IDLE, W_ADDR0, W_ADDR1, W_COUNT and DATA, `rd_uart` = !`rx_empty`, combinational. The FSM captures `r_data` on the same edge. In WRITE and ACK, `rd_uart`=0.
- Word assembly: a 2-bit byte index shifts bytes into a 32-bit register. On the 4th byte, the word and current address load into `mem_wdata`/`mem_addr` and the FSM enters WRITE.
- WRITE (one cycle): `mem_we`=1. On exit, address increments modulo 2^ADDR_W (wraps silently) and the word counter (9-bit) decrements.
- ACK: `wr_uart` = !`tx_full`, with `w_data` = the status register. The FSM leaves ACK on the edge where `wr_uart`=1 and stalls indefinitely while `tx_full`=1.
- `cpu_run` is cleared only by `reset`. A W command received after Go is still executed.
- Reset mid-command aborts it; no partial word is written. Bytes already in the FIFO are parsed from IDLE afterwards.

## Timing
- Reset values: `rd_uart`=0, `wr_uart`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `w_data`=0, `cpu_run`=0, `busy`=0, state=IDLE.
- Byte throughput: 1 byte per clock when the rx FIFO is non-empty; no bubble between consecutive bytes of a header or word.
- `mem_we` rises in the cycle after the edge consuming the 4th byte of a word, for exactly 1 cycle. `mem_addr`/`mem_wdata` are stable during it.
- Busy gaps: no byte is popped during WRITE, so each word costs ≥5 cycles.
- Last word: ACK is entered the cycle after its WRITE. `wr_uart` asserts that cycle if `tx_full`=0.
- `cpu_run` rises on the edge that consumes 'G', before the 'K' is queued.
- `busy` is registered from the state and rises the cycle after the command byte is consumed.
- The rx FIFO going empty mid-command simply stalls the FSM in place; no timeout.

## Test plan
- After reset, check all outputs at their reset values. Then feed 57 10 00 01 EF BE AD DE back-to-back. Expect one `mem_we` pulse with `mem_addr`=0x0010 and `mem_wdata`=0xDEADBEEF, then one `wr_uart` with `w_data`=0x4B.
- Burst with wrap: W, addr 0x3FFF, N=2, data words 0x11111111 and 0x22222222 (ADDR_W=14). Expect writes at 0x3FFF then 0x0000, then a single 'K'.
- Feed 'G' then an unknown byte 0x00. Expect `cpu_run`=1 from the edge consuming 'G', and `w_data` sequence 'K' then '?'. `cpu_run` stays 1.
- Rx starvation: W header followed by data bytes with random multi-cycle gaps. Expect identical writes, and no `rd_uart` while `rx_empty`=1.
- Tx backpressure: hold `tx_full`=1 during ACK for 20 cycles. Expect `wr_uart`=0, state held, no rx pops. Release → exactly one `wr_uart` of 'K'.
- Assert `reset` after 2 of 4 data bytes. Expect no `mem_we`, outputs return to reset values, and a following full W command completes normally.

Source files
------------

// File: rtl/uart_loader.sv
// uart_loader: boot-path command engine on the UART byte interface.
// Parses 'W' (write words), 'G' (release CPU) and replies with a status byte.
module uart_loader #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_empty,
   input  logic [7:0]        r_data,
   output logic              rd_uart,
   input  logic              tx_full,
   output logic              wr_uart,
   output logic [7:0]        w_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_run,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      W_ADDR0 = 3'd1,
      W_ADDR1 = 3'd2,
      W_COUNT = 3'd3,
      DATA    = 3'd4,
      WRITE   = 3'd5,
      ACK     = 3'd6
   } state_t;

   localparam logic [7:0] CMD_W   = 8'h57;
   localparam logic [7:0] CMD_G   = 8'h47;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_BAD = 8'h3F;

   state_t              state_r;
   state_t              state_n;
   logic                pop_s;
   logic                push_s;
   logic [7:0]          addr_lo_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [8:0]          cnt_r;
   logic [1:0]          idx_r;
   logic [31:0]         word_r;
   logic [7:0]          status_r;
   logic                mem_we_r;
   logic [ADDR_W-1:0]   mem_addr_r;
   logic [31:0]         mem_wdata_r;
   logic                cpu_run_r;
   logic                busy_r;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // Next-state logic plus the rx pop / tx push handshakes.
   always_comb begin
      state_n = state_r;
      pop_s   = 1'b0;
      push_s  = 1'b0;
      case (state_r)
         IDLE: begin
            pop_s = !rx_empty;
            if (pop_s) begin
               if (r_data == CMD_W) begin
                  state_n = W_ADDR0;
               end else begin
                  state_n = ACK;
               end
            end else begin
               state_n = IDLE;
            end
         end
         W_ADDR0: begin
            pop_s = !rx_empty;
            if (pop_s) begin
               state_n = W_ADDR1;
            end else begin
               state_n = W_ADDR0;
            end
         end
         W_ADDR1: begin
            pop_s = !rx_empty;
            if (pop_s) begin
               state_n = W_COUNT;
            end else begin
               state_n = W_ADDR1;
            end
         end
         W_COUNT: begin
            pop_s = !rx_empty;
            if (pop_s) begin
               state_n = DATA;
            end else begin
               state_n = W_COUNT;
            end
         end
         DATA: begin
            pop_s = !rx_empty;
            if (pop_s && (idx_r == 2'd3)) begin
               state_n = WRITE;
            end else begin
               state_n = DATA;
            end
         end
         WRITE: begin
            if (cnt_r == 9'd1) begin
               state_n = ACK;
            end else begin
               state_n = DATA;
            end
         end
         ACK: begin
            push_s = !tx_full;
            if (push_s) begin
               state_n = IDLE;
            end else begin
               state_n = ACK;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Command datapath: header capture, word assembly, write strobe, status.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_lo_r   <= 8'h00;
         addr_r      <= '0;
         cnt_r       <= 9'd0;
         idx_r       <= 2'd0;
         word_r      <= 32'h0000_0000;
         status_r    <= 8'h00;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= '0;
         mem_wdata_r <= 32'h0000_0000;
         cpu_run_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         // WRITE always lasts exactly one cycle, so the strobe follows it.
         mem_we_r <= (state_n == WRITE);
         busy_r   <= (state_n != IDLE);
         case (state_r)
            IDLE: begin
               if (pop_s) begin
                  if (r_data == CMD_G) begin
                     cpu_run_r <= 1'b1;
                     status_r  <= RSP_OK;
                  end else if (r_data != CMD_W) begin
                     status_r  <= RSP_BAD;
                  end
               end
            end
            W_ADDR0: begin
               if (pop_s) begin
                  addr_lo_r <= r_data;
               end
            end
            W_ADDR1: begin
               // Received 16-bit address is truncated to the memory width.
               if (pop_s) begin
                  addr_r <= ADDR_W'({r_data, addr_lo_r});
               end
            end
            W_COUNT: begin
               // A count byte of zero stands for 256 words.
               if (pop_s) begin
                  cnt_r <= (r_data == 8'h00) ? 9'd256 : {1'b0, r_data};
                  idx_r <= 2'd0;
               end
            end
            DATA: begin
               // Little-endian: bytes shift in from the top, first ends at 7:0.
               if (pop_s) begin
                  word_r <= {r_data, word_r[31:8]};
                  idx_r  <= idx_r + 2'd1;
                  if (idx_r == 2'd3) begin
                     mem_wdata_r <= {r_data, word_r[31:8]};
                     mem_addr_r  <= addr_r;
                  end
               end
            end
            WRITE: begin
               addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
               cnt_r  <= cnt_r - 9'd1;
               if (cnt_r == 9'd1) begin
                  status_r <= RSP_OK;
               end
            end
            ACK: begin
               status_r <= status_r;
            end
            default: begin
               status_r <= status_r;
            end
         endcase
      end
   end

   assign rd_uart   = pop_s && !reset;
   assign wr_uart   = push_s;
   assign w_data    = status_r;
   assign mem_we    = mem_we_r;
   assign mem_addr  = mem_addr_r;
   assign mem_wdata = mem_wdata_r;
   assign cpu_run   = cpu_run_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: rx FIFO model, protocol-level expectation queues,
// one negedge compare process, plus directed literal checks.
module tb_uart_loader;

   logic        clk;
   logic        reset;
   logic        rx_empty;
   logic [7:0]  r_data;
   logic        rd_uart;
   logic        tx_full;
   logic        wr_uart;
   logic [7:0]  w_data;
   logic        mem_we;
   logic [13:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_run;
   logic        busy;

   uart_loader #(.ADDR_W(14)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_empty  (rx_empty),
      .r_data    (r_data),
      .rd_uart   (rd_uart),
      .tx_full   (tx_full),
      .wr_uart   (wr_uart),
      .w_data    (w_data),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_run   (cpu_run),
      .busy      (busy)
   );

   typedef struct packed {
      logic [13:0] addr;
      logic [31:0] data;
      logic        last;
   } wr_t;

   logic [7:0]  rx_q[$];
   wr_t         exp_w[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] words_q[$];
   int          total = 0;
   int          bad = 0;
   bit          gap_en = 0;
   bit          want_ack = 0;
   bit          prev_we = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Build a W command from address and words; expectations come from arithmetic.
   task automatic cmd_w(input logic [15:0] a);
      int n;
      wr_t e;
      n = words_q.size();
      rx_q.push_back(8'h57);
      rx_q.push_back(a[7:0]);
      rx_q.push_back(a[15:8]);
      rx_q.push_back(8'(n % 256));
      for (int i = 0; i < n; i++) begin
         for (int b = 0; b < 4; b++) rx_q.push_back(words_q[i][8*b +: 8]);
         e.addr = 14'((int'(a) + i) % 16384);
         e.data = words_q[i];
         e.last = (i == n - 1);
         exp_w.push_back(e);
      end
      exp_tx.push_back(8'h4B);
      words_q.delete();
   endtask

   task automatic wait_idle(input string nm, input int budget);
      bit done;
      done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         if (rx_q.size() == 0 && exp_w.size() == 0 && exp_tx.size() == 0 && !busy) done = 1;
      end
      total++;
      if (!done) begin
         bad++;
         $display("FAIL %s: timeout, rx=%0d writes=%0d replies=%0d pending", nm,
                  rx_q.size(), exp_w.size(), exp_tx.size());
         rx_q.delete();
         exp_w.delete();
         exp_tx.delete();
      end
   endtask

   // rx FIFO model: pop on an edge where rd_uart was high, optional random gaps.
   initial begin
      bit pop;
      rx_empty = 1'b1;
      r_data   = 8'h00;
      forever begin
         @(negedge clk);
         pop = rd_uart;
         @(posedge clk);
         #1;
         if (pop && rx_q.size() > 0) void'(rx_q.pop_front());
         if (rx_q.size() == 0 || (gap_en && $urandom_range(0, 2) != 0)) begin
            rx_empty = 1'b1;
            r_data   = 8'h00;
         end else begin
            rx_empty = 1'b0;
            r_data   = rx_q[0];
         end
      end
   end

   // Compare process: writes, replies and handshake rules on every cycle.
   always @(negedge clk) begin
      wr_t e;
      if (reset) begin
         want_ack = 0;
         prev_we  = 0;
      end else begin
         if (rd_uart && rx_empty) chk("pop_while_empty", 32'(rd_uart), 32'd0);
         if (wr_uart && tx_full)  chk("push_while_full", 32'(wr_uart), 32'd0);
         if (mem_we && rd_uart)   chk("pop_during_write", 32'(rd_uart), 32'd0);
         if (prev_we)             chk("we_single_cycle", 32'(mem_we), 32'd0);
         if (want_ack && !tx_full) chk("ack_after_last_write", 32'(wr_uart), 32'd1);
         want_ack = 0;
         if (mem_we) begin
            if (exp_w.size() == 0) begin
               chk("unexpected_write_addr", 32'(mem_addr), 32'h0000_FFFF);
            end else begin
               e = exp_w.pop_front();
               chk("write_addr", 32'(mem_addr), 32'(e.addr));
               chk("write_data", mem_wdata, e.data);
               want_ack = e.last;
            end
         end
         if (wr_uart) begin
            if (exp_tx.size() == 0) begin
               chk("unexpected_reply", 32'(w_data), 32'h0000_FFFF);
            end else begin
               chk("reply_byte", 32'(w_data), 32'(exp_tx.pop_front()));
            end
         end
         prev_we = mem_we;
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rd_uart"},   32'(rd_uart),  32'd0);
      chk({tag, "_wr_uart"},   32'(wr_uart),  32'd0);
      chk({tag, "_mem_we"},    32'(mem_we),   32'd0);
      chk({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata,     32'd0);
      chk({tag, "_w_data"},    32'(w_data),   32'd0);
      chk({tag, "_cpu_run"},   32'(cpu_run),  32'd0);
      chk({tag, "_busy"},      32'(busy),     32'd0);
   endtask

   initial begin
      bit got;
      wr_t e;
      reset   = 1'b1;
      tx_full = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      reset = 1'b0;

      // Single word, literal expectation pins the model.
      rx_q.push_back(8'h57); rx_q.push_back(8'h10); rx_q.push_back(8'h00); rx_q.push_back(8'h01);
      rx_q.push_back(8'hEF); rx_q.push_back(8'hBE); rx_q.push_back(8'hAD); rx_q.push_back(8'hDE);
      e.addr = 14'h0010; e.data = 32'hDEADBEEF; e.last = 1'b1;
      exp_w.push_back(e);
      exp_tx.push_back(8'h4B);
      wait_idle("single_word", 100);

      // Burst wrapping past the top of the 14-bit address space.
      rx_q.push_back(8'h57); rx_q.push_back(8'hFF); rx_q.push_back(8'h3F); rx_q.push_back(8'h02);
      for (int i = 0; i < 4; i++) rx_q.push_back(8'h11);
      for (int i = 0; i < 4; i++) rx_q.push_back(8'h22);
      e.addr = 14'h3FFF; e.data = 32'h11111111; e.last = 1'b0;
      exp_w.push_back(e);
      e.addr = 14'h0000; e.data = 32'h22222222; e.last = 1'b1;
      exp_w.push_back(e);
      exp_tx.push_back(8'h4B);
      wait_idle("wrap_burst", 100);
      chk("run_before_go", 32'(cpu_run), 32'd0);

      // Rx starvation with random gaps between bytes.
      gap_en = 1;
      words_q.push_back(32'hA5A55A5A);
      words_q.push_back(32'h0BADF00D);
      words_q.push_back(32'h12345678);
      cmd_w(16'h0123);
      wait_idle("starved_burst", 400);
      gap_en = 0;

      // Go, then an unknown command byte.
      rx_q.push_back(8'h47);
      exp_tx.push_back(8'h4B);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (rd_uart) got = 1;
      end
      chk("go_popped", 32'(got), 32'd1);
      chk("run_before_go_edge", 32'(cpu_run), 32'd0);
      @(posedge clk);
      #1;
      chk("run_after_go_edge", 32'(cpu_run), 32'd1);
      rx_q.push_back(8'h00);
      exp_tx.push_back(8'h3F);
      wait_idle("go_then_unknown", 100);
      chk("run_sticky", 32'(cpu_run), 32'd1);

      // Tx backpressure during ACK, with another command waiting in the FIFO.
      @(negedge clk);
      tx_full = 1'b1;
      words_q.push_back(32'h01020304);
      cmd_w(16'h0005);
      rx_q.push_back(8'h47);
      exp_tx.push_back(8'h4B);
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (exp_w.size() == 0) got = 1;
      end
      chk("bp_write_seen", 32'(got), 32'd1);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wr_uart || rd_uart || !busy) begin
            chk("bp_held_wr", 32'(wr_uart), 32'd0);
            chk("bp_held_rd", 32'(rd_uart), 32'd0);
            chk("bp_held_busy", 32'(busy), 32'd1);
         end
      end
      chk("bp_rx_untouched", 32'(rx_q.size()), 32'd1);
      chk("bp_reply_pending", 32'(exp_tx.size()), 32'd2);
      tx_full = 1'b0;
      wait_idle("bp_release", 100);

      // Reset after 2 of 4 data bytes: nothing written, then a clean command.
      rx_q.push_back(8'h57); rx_q.push_back(8'h00); rx_q.push_back(8'h01); rx_q.push_back(8'h01);
      rx_q.push_back(8'hAA); rx_q.push_back(8'hBB);
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (rx_q.size() == 0) got = 1;
      end
      chk("partial_consumed", 32'(got), 32'd1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("mid_rst");
      @(negedge clk);
      reset = 1'b0;
      words_q.push_back(32'hCAFEF00D);
      cmd_w(16'h0200);
      wait_idle("after_reset_cmd", 100);
      chk("run_cleared_by_reset", 32'(cpu_run), 32'd0);

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
